// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit FIFO plus launch sequencer in front of a UART transmitter.
// Buffers host bytes and hands them out one at a time, waiting for tx_done_tick between launches.
module uart_tx_fifo_ctrl #(
   parameter int DBIT   = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [DBIT-1:0]   wr_data,
   input  logic              tx_done_tick,
   output logic              tx_start,
   output logic [DBIT-1:0]   tx_din,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              overflow
);
   // state    | meaning
   // S_IDLE   | transmitter free; launch the head byte if the FIFO holds one
   // S_LAUNCH | tx_start high for exactly this cycle
   // S_WAIT   | byte in flight; waiting for tx_done_tick
   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_LAUNCH = 2'b01,
      S_WAIT   = 2'b10
   } state_t;

   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [DBIT-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   state_t            state;
   state_t            state_next;
   logic              pop;
   logic              busy_clr;
   logic              wr_ok;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   // A pop in the same cycle frees a slot, so a write while full is still accepted then.
   assign wr_ok = wr_en && (!full || pop);

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      busy_clr   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = S_LAUNCH;
            end
         end
         S_LAUNCH: state_next = S_WAIT;
         S_WAIT: begin
            if (tx_done_tick) begin
               busy_clr   = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: begin
            busy_clr   = 1'b1;
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         tx_start <= 1'b0;
         tx_din   <= '0;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            tx_din <= mem[rd_ptr];
         end
         if (wr_ok && !pop)      count <= count + CNT_ONE;
         else if (pop && !wr_ok) count <= count - CNT_ONE;
         tx_start <= pop;
         if (pop)           busy <= 1'b1;
         else if (busy_clr) busy <= 1'b0;
         if (wr_en && !wr_ok) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Randomized bench for uart_tx_fifo_ctrl against a queue-based reference model.
module tb_uart_tx_fifo_ctrl;
   localparam int DBIT   = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              wr_en = 1'b0;
   logic [DBIT-1:0]   wr_data = '0;
   logic              tx_done_tick = 1'b0;
   logic              tx_start;
   logic [DBIT-1:0]   tx_din;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              busy;
   logic              overflow;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   uart_tx_fifo_ctrl #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .tx_done_tick (tx_done_tick),
      .tx_start     (tx_start),
      .tx_din       (tx_din),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .busy         (busy),
      .overflow     (overflow)
   );

   // Reference: a queue of waiting bytes and one outstanding transmission.
   logic [7:0] mq[$];
   bit         m_busy, m_start, m_ovf, m_launch, m_done;
   logic [7:0] m_din = '0;

   always @(posedge clk) begin
      if (!reset_n) begin
         mq.delete();
         m_busy  = 1'b0;
         m_start = 1'b0;
         m_ovf   = 1'b0;
         m_din   = '0;
      end else begin
         m_launch = !m_busy && (mq.size() != 0);
         m_done   = m_busy && !m_start && tx_done_tick;
         if (m_launch) m_din = mq.pop_front();
         if (wr_en) begin
            if (mq.size() < DEPTH) mq.push_back(wr_data);
            else                   m_ovf = 1'b1;
         end
         m_start = m_launch;
         if (m_launch)    m_busy = 1'b1;
         else if (m_done) m_busy = 1'b0;
      end
   end

   logic [17:0] exp_v, act_v;
   logic [4:0]  m_cnt;
   always @(negedge clk) begin
      if (chk_en) begin
         m_cnt = 5'(mq.size());
         exp_v = {m_start, m_busy, mq.size() == DEPTH, mq.size() == 0, m_ovf, m_cnt, m_din};
         act_v = {tx_start, busy, full, empty, overflow, count, tx_din};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs @%0t: got start=%0b busy=%0b full=%0b empty=%0b ovf=%0b count=%0d din=%02h, expected start=%0b busy=%0b full=%0b empty=%0b ovf=%0b count=%0d din=%02h",
                     $time, tx_start, busy, full, empty, overflow, count, tx_din,
                     m_start, m_busy, mq.size() == DEPTH, mq.size() == 0, m_ovf, m_cnt, m_din);
         end
      end
   end

   logic [7:0] txlog[$];
   always @(negedge clk) begin
      if (chk_en && tx_start === 1'b1) txlog.push_back(tx_din);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input bit we, input logic [7:0] d, input bit done);
      wr_en        = we;
      wr_data      = d;
      tx_done_tick = done;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step(1'b0, 8'h00, 1'b0);
      reset_n = 1'b1;
      txlog.delete();
   endtask

   task automatic drain(input int max_cyc, output bit ok);
      bit d;
      ok = 1'b0;
      for (int k = 0; k < max_cyc; k++) begin
         d = busy && ($urandom_range(0, 3) == 0);
         step(1'b0, 8'h00, d);
         if (empty && !busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   bit         ok;
   int         starts[$];
   int         ts;
   int         nw;
   int         maxc;
   bit         we, d;
   logic [7:0] vals3 [3];

   initial begin
      @(negedge clk);
      // 1: single byte
      do_reset();
      chk_en = 1'b1;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_start", 32'(tx_start), 0);
      chk("rst_din", 32'(tx_din), 0);
      chk("rst_ovf", 32'(overflow), 0);
      step(1'b1, 8'hA5, 1'b0);
      chk("t1_count_after_wr", 32'(count), 1);
      chk("t1_start_early", 32'(tx_start), 0);
      step(1'b0, 8'h00, 1'b0);
      chk("t1_start", 32'(tx_start), 1);
      chk("t1_din", 32'(tx_din), 32'hA5);
      chk("t1_count_after_pop", 32'(count), 0);
      step(1'b0, 8'h00, 1'b0);
      chk("t1_start_width", 32'(tx_start), 0);
      repeat (5) step(1'b0, 8'h00, 1'b0);
      chk("t1_busy_hold", 32'(busy), 1);
      chk("t1_din_hold", 32'(tx_din), 32'hA5);
      step(1'b0, 8'h00, 1'b1);
      chk("t1_busy_done", 32'(busy), 0);
      chk("t1_empty_done", 32'(empty), 1);

      // 2: burst to full, overflow
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
      chk("t2_count15", 32'(count), 15);
      chk("t2_notfull", 32'(full), 0);
      step(1'b1, 8'h10, 1'b0);
      chk("t2_full", 32'(full), 1);
      chk("t2_ovf_clear", 32'(overflow), 0);
      step(1'b1, 8'hFF, 1'b0);
      chk("t2_ovf_set", 32'(overflow), 1);
      chk("t2_count16", 32'(count), 16);
      drain(2000, ok);
      chk("t2_drain", 32'(ok), 1);
      chk("t2_len", 32'(txlog.size()), 17);
      for (int i = 0; i < txlog.size() && i < 17; i++) chk("t2_order", 32'(txlog[i]), 32'(i));
      chk("t2_ovf_sticky", 32'(overflow), 1);

      // 3: spacing with done 20 cycles after each start
      do_reset();
      vals3[0] = 8'h11; vals3[1] = 8'h22; vals3[2] = 8'h33;
      starts.delete();
      ts = -100;
      for (int k = 0; k < 200; k++) begin
         d  = (k == ts + 20);
         we = (k < 3);
         if (we) step(1'b1, vals3[k], d);
         else    step(1'b0, 8'h00, d);
         if (tx_start) begin
            starts.push_back(k + 1);
            ts = k + 1;
         end
         if (starts.size() == 3 && !busy) break;
      end
      chk("t3_nstarts", 32'(starts.size()), 3);
      if (starts.size() == 3) begin
         chk("t3_gap1", 32'(starts[1] - starts[0]), 22);
         chk("t3_gap2", 32'(starts[2] - starts[1]), 22);
      end
      chk("t3_len", 32'(txlog.size()), 3);
      if (txlog.size() == 3) begin
         chk("t3_b0", 32'(txlog[0]), 32'h11);
         chk("t3_b1", 32'(txlog[1]), 32'h22);
         chk("t3_b2", 32'(txlog[2]), 32'h33);
      end

      // 4: write while full in the pop cycle
      do_reset();
      step(1'b1, 8'hB0, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
      chk("t4_full", 32'(full), 1);
      chk("t4_busy", 32'(busy), 1);
      step(1'b0, 8'h00, 1'b1);
      chk("t4_idle", 32'(busy), 0);
      step(1'b1, 8'h5A, 1'b0);
      chk("t4_count", 32'(count), 16);
      chk("t4_ovf", 32'(overflow), 0);
      chk("t4_start", 32'(tx_start), 1);
      chk("t4_din", 32'(tx_din), 32'h40);
      drain(2000, ok);
      chk("t4_drain", 32'(ok), 1);
      chk("t4_len", 32'(txlog.size()), 18);
      if (txlog.size() == 18) begin
         chk("t4_first", 32'(txlog[0]), 32'hB0);
         chk("t4_last", 32'(txlog[17]), 32'h5A);
      end

      // 5: wrap-around with random bursts
      do_reset();
      nw = 0;
      maxc = 0;
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         we = (nw < 40) && (mq.size() < DEPTH) && ($urandom_range(0, 2) != 0);
         d  = busy && ($urandom_range(0, 2) == 0);
         step(we, 8'(nw), d);
         if (we) nw++;
         if (int'(count) > maxc) maxc = int'(count);
         if (nw == 40 && empty && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t5_done", 32'(ok), 1);
      chk("t5_len", 32'(txlog.size()), 40);
      for (int i = 0; i < txlog.size() && i < 40; i++) chk("t5_order", 32'(txlog[i]), 32'(i));
      chk("t5_maxcount_ok", 32'(maxc <= 16), 1);
      chk("t5_empty", 32'(empty), 1);
      chk("t5_ovf", 32'(overflow), 0);

      // 6: reset during S_WAIT
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b0);
      chk("t6_queued", 32'(count), 5);
      chk("t6_busy", 32'(busy), 1);
      reset_n = 1'b0;
      step(1'b0, 8'h00, 1'b0);
      reset_n = 1'b1;
      chk("t6_count", 32'(count), 0);
      chk("t6_empty", 32'(empty), 1);
      chk("t6_busy0", 32'(busy), 0);
      chk("t6_start0", 32'(tx_start), 0);
      chk("t6_ovf0", 32'(overflow), 0);
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("t6_no_launch", 32'(tx_start), 0);
         step(1'b0, 8'h00, 1'b0);
      end
      chk("t6_busy_stays0", 32'(busy), 0);
      chk("t6_log", 32'(txlog.size()), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
